// File: rtl/fdiv_iter.sv
// fdiv_iter -- multi-cycle floating-point divider (radix-2 restoring).
//
// Operands and result use the split sign/exp/frac format of the FPU datapath.
// Only one divide is in flight at a time, with a valid/ready handshake on each side.
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake; operands are captured when both are high
//   A_*, B_*          : dividend / divisor sign, exponent, stored fraction
//   out_valid/out_ready : result handshake; the result is held until it is accepted
//   sign, exp, frac   : result
//   error             : invalid operation, result is the canonical NaN
//   overflow          : result forced to infinity (exponent overflow or infinite dividend)
//   underflow         : result flushed to zero by exponent underflow
//   div_by_zero       : finite non-zero value divided by zero
//
// Build option: define FDIV_ROUND_EN for round-to-nearest-even.
// Without it, the quotient is truncated. Latency is the same in both builds.
module fdiv_iter #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = 2**(EXP_W-1)-1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              A_sign,
  input  logic [EXP_W-1:0]  A_exp,
  input  logic [FRAC_W-1:0] A_frac,
  input  logic              B_sign,
  input  logic [EXP_W-1:0]  B_exp,
  input  logic [FRAC_W-1:0] B_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] frac,
  output logic              error,
  output logic              overflow,
  output logic              underflow,
  output logic              div_by_zero
);

  localparam int M_W   = FRAC_W + 1;   // mantissa including the hidden bit
  localparam int R_W   = FRAC_W + 2;   // partial remainder
  localparam int Q_W   = FRAC_W + 3;   // quotient: one integer bit plus FRAC_W+2 fraction bits
  localparam int E_W   = EXP_W + 2;    // signed working exponent
  localparam int CNT_W = $clog2(Q_W);

  localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(Q_W - 1);
  localparam logic [EXP_W-1:0]      EXP_ONES  = '1;
  localparam logic [FRAC_W-1:0]     NAN_FRAC  = {1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [E_W-1:0] E_MAX     = E_W'(2**EXP_W - 1);
  localparam logic signed [E_W-1:0] E_ZERO    = '0;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;
  state_t state, state_nx;

  logic [EXP_W-1:0] a_exp_r, b_exp_r;
  logic [R_W-1:0]   rem;
  logic [M_W-1:0]   dvsr;
  logic [Q_W-1:0]   quo;
  logic [CNT_W-1:0] cnt;

  // Operand classification and special-case selection
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic sp_nan, sp_dbz, sp_ovf, sp_zero, special;

  always_comb begin
    a_zero  = (A_exp == '0);
    a_inf   = (A_exp == EXP_ONES) && (A_frac == '0);
    a_nan   = (A_exp == EXP_ONES) && (A_frac != '0);
    b_zero  = (B_exp == '0);
    b_inf   = (B_exp == EXP_ONES) && (B_frac == '0);
    b_nan   = (B_exp == EXP_ONES) && (B_frac != '0);
    sp_nan  = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
    // The later cases rely on sp_nan having removed the combinations handled above.
    sp_dbz  = !sp_nan && b_zero && !a_zero && !a_inf;
    sp_ovf  = !sp_nan && a_inf;
    sp_zero = !sp_nan && (a_zero || b_inf);
    special = sp_nan || sp_dbz || sp_ovf || sp_zero;
  end

  // One restoring-division step. The subtracted remainder is always below the divisor,
  // so dropping its MSB in the shift loses nothing.
  logic           q_bit;
  logic [R_W-1:0] rem_nx;

  always_comb begin
    q_bit  = (rem >= {1'b0, dvsr});
    rem_nx = q_bit ? ((rem - {1'b0, dvsr}) << 1) : (rem << 1);
  end

  // Normalisation, optional rounding and exponent range check
  logic                  hi, guard, sticky;
  logic [FRAC_W-1:0]     mfrac;
  logic signed [E_W-1:0] e_n;
  logic [EXP_W-1:0]      n_exp;
  logic [FRAC_W-1:0]     n_frac;
  logic                  n_ovf, n_unf;
`ifdef FDIV_ROUND_EN
  logic [FRAC_W:0]       mfrac_sum;
`else
  logic                  unused_round;
`endif

  always_comb begin
    hi     = quo[Q_W-1];
    sticky = (rem != '0);
    e_n    = {2'b00, a_exp_r} - {2'b00, b_exp_r} + E_W'(BIAS);
    if (hi) begin
      mfrac  = quo[Q_W-2:2];
      guard  = quo[1];
      sticky = sticky | quo[0];
    end else begin
      mfrac  = quo[FRAC_W:1];
      guard  = quo[0];
      e_n    = e_n - E_W'(1);
    end
`ifdef FDIV_ROUND_EN
    mfrac_sum = {1'b0, mfrac} + {{FRAC_W{1'b0}}, guard & (sticky | mfrac[0])};
    // On a carry out, the low bits are already zero and the mantissa becomes 1.0 * 2.
    if (mfrac_sum[FRAC_W]) e_n = e_n + E_W'(1);
    mfrac = mfrac_sum[FRAC_W-1:0];
`else
    unused_round = guard ^ sticky;
`endif
    n_exp  = '0;
    n_frac = '0;
    n_ovf  = 1'b0;
    n_unf  = 1'b0;
    if (e_n >= E_MAX) begin
      n_exp = '1;
      n_ovf = 1'b1;
    end else if (e_n <= E_ZERO) begin
      n_unf = 1'b1;
    end else begin
      n_exp  = e_n[EXP_W-1:0];
      n_frac = mfrac;
    end
  end

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = special ? DONE : DIVIDE;
      end
      DIVIDE: if (cnt == LAST_STEP) state_nx = NORM;
      NORM:   state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_exp_r     <= '0;
      b_exp_r     <= '0;
      rem         <= '0;
      dvsr        <= '0;
      quo         <= '0;
      cnt         <= '0;
      sign        <= 1'b0;
      exp         <= '0;
      frac        <= '0;
      error       <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          a_exp_r     <= A_exp;
          b_exp_r     <= B_exp;
          rem         <= {1'b0, 1'b1, A_frac};
          dvsr        <= {1'b1, B_frac};
          quo         <= '0;
          cnt         <= '0;
          sign        <= sp_nan ? 1'b0 : (A_sign ^ B_sign);
          error       <= 1'b0;
          overflow    <= 1'b0;
          underflow   <= 1'b0;
          div_by_zero <= 1'b0;
          if (sp_nan) begin
            exp   <= '1;
            frac  <= NAN_FRAC;
            error <= 1'b1;
          end else if (sp_dbz) begin
            exp         <= '1;
            frac        <= '0;
            div_by_zero <= 1'b1;
          end else if (sp_ovf) begin
            exp      <= '1;
            frac     <= '0;
            overflow <= 1'b1;
          end else if (sp_zero) begin
            exp  <= '0;
            frac <= '0;
          end
        end
        DIVIDE: begin
          rem <= rem_nx;
          quo <= {quo[Q_W-2:0], q_bit};
          cnt <= cnt + CNT_W'(1);
        end
        NORM: begin
          exp       <= n_exp;
          frac      <= n_frac;
          overflow  <= n_ovf;
          underflow <= n_unf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_iter.sv
// tb_fdiv_iter -- self-checking bench for fdiv_iter.
// The stimulus side pushes the expected result of each accepted operation into a queue.
// A separate monitor compares every presented result against the queue head
// and pops the head on the output handshake.
module tb_fdiv_iter;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 2**(EXP_W-1)-1;
  localparam int EMAX   = 2**EXP_W - 1;
  localparam int W      = 1 + EXP_W + FRAC_W;

  logic              clk, rst;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic              a_sign, b_sign;
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [FRAC_W-1:0] a_frac, b_frac;
  logic              sign, error, overflow, underflow, div_by_zero;
  logic [EXP_W-1:0]  exp;
  logic [FRAC_W-1:0] frac;

  fdiv_iter #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .BIAS(BIAS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A_sign(a_sign), .A_exp(a_exp), .A_frac(a_frac),
    .B_sign(b_sign), .B_exp(b_exp), .B_frac(b_frac),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .exp(exp), .frac(frac),
    .error(error), .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic rand_bp = 1'b0;

  typedef struct {
    logic              s;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    logic              err, ovf, unf, dbz;
    int                lat;
    int                cap;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: exact integer quotient of the mantissas, then normalise, round and range-check.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    logic as, bs, az, ai, an, bz, bi, bn, g, st;
    int ae, be, e;
    longint unsigned af, bf, ma, mb, num, q, rm, f, mask;
    as = a[W-1];  ae = int'(a[W-2:FRAC_W]);  af = longint'(a[FRAC_W-1:0]);
    bs = b[W-1];  be = int'(b[W-2:FRAC_W]);  bf = longint'(b[FRAC_W-1:0]);
    mask = (64'd1 << FRAC_W) - 1;
    az = (ae == 0);  ai = (ae == EMAX) && (af == 0);  an = (ae == EMAX) && (af != 0);
    bz = (be == 0);  bi = (be == EMAX) && (bf == 0);  bn = (be == EMAX) && (bf != 0);
    r.s = as ^ bs;  r.e = '0;  r.f = '0;
    r.err = 1'b0;  r.ovf = 1'b0;  r.unf = 1'b0;  r.dbz = 1'b0;
    r.lat = 1;  r.cap = 0;
    if (an || bn || (az && bz) || (ai && bi)) begin
      r.s = 1'b0;  r.e = EXP_W'(EMAX);  r.f = FRAC_W'(64'd1 << (FRAC_W-1));  r.err = 1'b1;
    end else if (bz && !az && !ai) begin
      r.e = EXP_W'(EMAX);  r.dbz = 1'b1;
    end else if (ai) begin
      r.e = EXP_W'(EMAX);  r.ovf = 1'b1;
    end else if (az || bi) begin
      r.e = '0;
    end else begin
      r.lat = FRAC_W + 5;
      ma  = (64'd1 << FRAC_W) | af;
      mb  = (64'd1 << FRAC_W) | bf;
      num = ma << (FRAC_W + 2);
      q   = num / mb;
      rm  = num % mb;
      e   = ae - be + BIAS;
      if (q >= (64'd1 << (FRAC_W + 2))) begin
        f  = (q >> 2) & mask;
        g  = q[1];
        st = q[0] || (rm != 0);
      end else begin
        f  = (q >> 1) & mask;
        g  = q[0];
        st = (rm != 0);
        e  = e - 1;
      end
`ifdef FDIV_ROUND_EN
      if (g && (st || f[0])) f = f + 1;
      if (f > mask) begin
        f = 0;
        e = e + 1;
      end
`else
      if (g && st) f = f;
`endif
      if (e >= EMAX) begin
        r.e = EXP_W'(EMAX);  r.ovf = 1'b1;
      end else if (e <= 0) begin
        r.unf = 1'b1;
      end else begin
        r.e = EXP_W'(e);  r.f = FRAC_W'(f);
      end
    end
    return r;
  endfunction

  task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    a_sign = a[W-1];  a_exp = a[W-2:FRAC_W];  a_frac = a[FRAC_W-1:0];
    b_sign = b[W-1];  b_exp = b[W-2:FRAC_W];  b_frac = b[FRAC_W-1:0];
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    int c;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 300) begin
        checks++;
        failures++;
        $display("FAIL issue_timeout in_ready=%b want=1", in_ready);
        return;
      end
      @(negedge clk);
    end
    drive_ops(a, b);
    in_valid = 1'b1;
    c = cyc + 1;
    @(posedge clk);
    x = model(a, b);
    x.cap = c;
    sb.push_back(x);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || !in_ready) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d in_ready=%b want pending=0", sb.size(), in_ready);
      sb.delete();
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    int mode;
    mode = $urandom_range(0, 15);
    f = FRAC_W'($urandom());
    case (mode)
      0:       e = '0;
      1: begin e = EXP_W'(EMAX); f = '0; end
      2:       e = EXP_W'(EMAX);
      3:       e = EXP_W'($urandom_range(1, 4));
      4:       e = EXP_W'($urandom_range(EMAX - 4, EMAX - 1));
      default: e = EXP_W'($urandom_range(1, EMAX - 1));
    endcase
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  // Monitor
  initial begin : monitor
    exp_t x;
    logic prev_v;
    int lat;
    int idx;
    prev_v = 1'b0;
    idx = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_v = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output e=%0d f=%h want no output", exp, frac);
        end else begin
          x = sb[0];
          if (!prev_v) begin
            lat = cyc - x.cap + 1;
            checks++;
            if (lat != x.lat) begin
              failures++;
              $display("FAIL latency[%0d] got=%0d want=%0d", idx, lat, x.lat);
            end
          end
          checks++;
          if ({sign, exp, frac, error, overflow, underflow, div_by_zero} !==
              {x.s, x.e, x.f, x.err, x.ovf, x.unf, x.dbz}) begin
            failures++;
            $display("FAIL result[%0d] got s=%b e=%0d f=%h err/ovf/unf/dbz=%b%b%b%b want s=%b e=%0d f=%h err/ovf/unf/dbz=%b%b%b%b",
                     idx, sign, exp, frac, error, overflow, underflow, div_by_zero,
                     x.s, x.e, x.f, x.err, x.ovf, x.unf, x.dbz);
          end
          if (out_ready) begin
            void'(sb.pop_front());
            idx++;
          end
        end
      end
      prev_v = out_valid && !out_ready;
    end
  end

  // Random output backpressure
  initial begin
    forever begin
      @(negedge clk);
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  localparam int ND = 16;
  logic [W-1:0] dir_a [ND] = '{
    32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
    32'h00000000, 32'h7F800000, 32'h40A00000, 32'h7F000000,
    32'h00800000, 32'h7F800001, 32'hFF800000, 32'h00000000,
    32'h00123456, 32'h7F000000, 32'h00800000, 32'h7F000000
  };
  logic [W-1:0] dir_b [ND] = '{
    32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000,
    32'h00000000, 32'h7F800000, 32'h7F800000, 32'h00800000,
    32'h7F000000, 32'h3F800000, 32'h00000000, 32'hFF800000,
    32'h40000000, 32'h3F000000, 32'h40000000, 32'h3F800000
  };

  initial begin : stim
    int n;
    int c2;
    exp_t x;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive_ops('0, '0);
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_outputs", 64'({out_valid, sign, exp, frac, error, overflow, underflow, div_by_zero}), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'({in_ready, out_valid}), 64'b10);

    // Directed vectors, including the exponent-range boundaries
    out_ready = 1'b1;
    for (int i = 0; i < ND; i++) issue(dir_a[i], dir_b[i]);
    wait_drain();

    // Random operations with random output backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 250; i++) issue(rand_op(), rand_op());
    wait_drain();
    rand_bp = 1'b0;
    @(negedge clk);

    // Held result while out_ready is low, and a second request is stalled meanwhile
    out_ready = 1'b0;
    issue(32'h40C00000, 32'h40000000);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_result_arrives", 64'(out_valid), 64'd1);
    drive_ops(32'h3F800000, 32'h40400000);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_in_ready_low", 64'({in_ready, out_valid}), 64'b01);
      @(negedge clk);
    end
    out_ready = 1'b1;
    c2 = cyc + 2;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_after_handshake", 64'({in_ready, out_valid}), 64'b10);
    @(posedge clk);
    x = model(32'h3F800000, 32'h40400000);
    x.cap = c2;
    sb.push_back(x);
    #1 in_valid = 1'b0;
    wait_drain();

    // Reset in the middle of a divide
    issue(32'h3F800000, 32'h40400000);
    wait_drain();
    issue(32'h40C00000, 32'h40000000);
    repeat (10) @(negedge clk);
    chk("mid_divide_busy", 64'({in_ready, out_valid}), 64'b00);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("async_reset_clears", 64'({out_valid, sign, exp, frac, error, overflow, underflow, div_by_zero}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", 64'({in_ready, out_valid}), 64'b10);
    issue(32'h40C00000, 32'h40000000);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fdiv_iter.md
Name: fdiv_iter

Overview:
Parametrised, multi-cycle IEEE-754-style floating-point divider. It is the successor to the single-cycle combinational divider and generalises exponent and fraction width. It uses radix-2 restoring division with a valid/ready handshake on both sides, one divide in flight at a time. It sits in the FPU datapath beside the adder and multiplier and uses the same split sign/exp/frac operand format.

Parameters:
EXP_W, 8, exponent field width
FRAC_W, 23, stored fraction width (hidden bit excluded)
BIAS, 2**(EXP_W-1)-1, exponent bias

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  operands valid
in_ready  out  1  divider can accept operands
A_sign  in  1  dividend sign
A_exp  in  EXP_W  dividend exponent
A_frac  in  FRAC_W  dividend fraction
B_sign  in  1  divisor sign
B_exp  in  EXP_W  divisor exponent
B_frac  in  FRAC_W  divisor fraction
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sign  out  1  result sign
exp  out  EXP_W  result exponent
frac  out  FRAC_W  result fraction
error  out  1  invalid operation; result is NaN
overflow  out  1  result forced to infinity by exponent overflow or infinite dividend
underflow  out  1  result flushed to zero by exponent underflow
div_by_zero  out  1  finite non-zero value divided by zero

Behaviour:
- Reset (async): state=IDLE; out_valid, sign, exp, frac and all flags = 0; in_ready = 1 when rst deasserts. Reset in any state aborts the divide with no output.
- in_ready = (state==IDLE). Operands are captured on a clock edge where in_valid & in_ready.
- States: IDLE -> DIVIDE -> NORM -> DONE -> IDLE. A special case goes IDLE -> DONE directly.
- Classification at capture. exp==0 means zero (denormals flush to zero, frac ignored). exp all-ones with frac==0 means inf. exp all-ones with frac!=0 means NaN.
- Special-case priority:
  (1) any NaN, 0/0 or inf/inf -> canonical NaN (exp all-ones, frac MSB=1, rest 0, sign 0), error=1.
  (2) finite non-zero / 0 -> inf, div_by_zero=1.
  (3) inf / finite -> inf, overflow=1.
  (4) 0 / non-NaN, or finite / inf -> zero (exp=0, frac=0).
  Sign = A_sign^B_sign in all cases except NaN.
- Special-case latency: out_valid is high after the capturing edge (1 cycle).
- DIVIDE: the remainder starts at {1,A_frac} and the divisor is {1,B_frac}. Each cycle produces one quotient bit (remainder-divisor >= 0 gives bit 1 and the remainder is updated), then the remainder shifts left. DIVIDE runs exactly FRAC_W+3 cycles, counted by an internal counter, giving quotient q[FRAC_W+2:0] in [0.5,2).
- NORM (1 cycle):
  - If q[FRAC_W+2]=1: frac=q[FRAC_W+1:2], guard=q[1], sticky=q[0] | (rem!=0), e=A_exp-B_exp+BIAS.
  - Otherwise: frac=q[FRAC_W:1], guard=q[0], sticky=(rem!=0), e=A_exp-B_exp+BIAS-1.
  - e is computed signed, EXP_W+2 bits wide.
  - e >= 2^EXP_W-1 -> inf, overflow=1. e <= 0 -> zero, underflow=1.
- Normal-path latency: FRAC_W+5 edges from capture to out_valid (28 with defaults).
- DONE: out_valid=1. Outputs and flags stay stable until out_ready. On the edge with out_valid & out_ready: out_valid drops, state goes to IDLE and in_ready=1 the next cycle. No back-to-back overlap.
- Flags are valid only while out_valid=1, and are cleared at the start of each new capture.

Optional Feature:
FDIV_ROUND_EN
- Defined: round-to-nearest-even in NORM. Increment frac when guard & (sticky | frac[0]).
- A carry out of the fraction clears frac and increments e before the overflow check; reaching all-ones gives inf with overflow=1.
- Undefined: truncation (guard and sticky ignored). Latency is identical either way.

Test Plan:
- 6.0/2.0: A(0,129,0x400000), B(0,128,0x000000) -> out_valid 28 cycles after capture; result (0,128,0x400000), all flags 0.
- 1.0/3.0: A(0,127,0), B(0,128,0x400000) -> (0,125,0x2AAAAA) without macro; (0,125,0x2AAAAB) with FDIV_ROUND_EN. Also -1.0/3.0 gives sign=1.
- Specials, each 1-cycle latency:
  - 1.0/0 -> (0,255,0), div_by_zero=1.
  - 0/0 -> (0,255,0x400000), error=1.
  - inf/inf -> NaN, error=1.
  - 5.0/inf -> (0,0,0).
- Range: A exp=254 / B exp=1 -> inf, overflow=1. A exp=1 / B exp=254 -> zero, underflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Outputs and flags remain stable; in_ready=0; a second in_valid is not captured.
  - Release out_ready: the second operand is captured the cycle after the handshake.
- Reset mid-divide: assert rst at cycle 10 of DIVIDE.
  - out_valid=0 and all outputs are 0 immediately (async).
  - After release, in_ready=1 and a new 6.0/2.0 completes correctly in 28 cycles.
